regfile_mp_sb: RTL
==================

Name: regfile_mp_sb

Overview:
- Parametrised multi-port general-purpose register file for the CPU core, with a per-register pending-write scoreboard.
- Serves decode/issue: read ports give operands with same-cycle write-back bypass; a busy flag per register marks outstanding producers.
- Register 0 is hardwired to zero.
- Intended successor of the fixed 2-read/1-write file, with configurable width, depth and port counts.

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W entries.
- NR, 2, number of read ports (1..4).
- NW, 2, number of write ports (1..3).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- raddr  input  NR*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rdata  output  NR*DATA_W  read data, port i at [i*DATA_W +: DATA_W].
- rbusy  output  NR  read port i's register has an outstanding producer.
- wen  input  NW  write enable per write port.
- waddr  input  NW*ADDR_W  write addresses, packed as raddr.
- wdata  input  NW*DATA_W  write data, packed as rdata.
- issue_en  input  1  mark issue_addr as pending (new producer issued).
- issue_addr  input  ADDR_W  register receiving a new producer.
- flush  input  1  clear all busy flags (pipeline flush).
- busy_cnt  output  ADDR_W+1  number of registers currently marked busy.

Behaviour:
- Single clock domain.
- Reset is synchronous, active-high, named rst; clock is named clk.
- Reset: all DEPTH entries, including entry 0, set to 0; all busy flags 0; busy_cnt = 0.
- Reset overrides writes, issue and flush in the same cycle.
- Read (combinational, zero latency):
  - raddr_i == 0 -> rdata_i = 0, rbusy_i = 0.
  - Otherwise, if any enabled write port targets raddr_i, rdata_i = wdata of the highest-indexed such port (bypass).
  - Otherwise rdata_i = stored entry.
- Write (rising edge):
  - Each enabled port with waddr != 0 updates its entry.
  - Same-address conflict: the highest-indexed port wins.
  - Writes to address 0 are dropped.
- Busy flags (rising edge, in priority order):
  1. flush=1: all flags cleared; issue_en that cycle is ignored. Writes still commit data.
  2. Else issue_en=1 and issue_addr != 0: flag[issue_addr] set. This wins over a same-cycle write to the same address, because the newer producer is still outstanding.
  3. Else any enabled write to addr a != 0 clears flag[a].
  - issue_addr == 0 is ignored; flag 0 is never set.
- rbusy_i = flag_q[raddr_i] AND no enabled write targets raddr_i this cycle.
  - The bypassed value is valid, so the consumer need not stall.
  - A same-cycle issue does not affect rbusy until the next cycle.
- busy_cnt: registered population count of the flags, updated in the same edge as the flags; range 0..DEPTH-1.
  - Maintain as a counter: +1 on a 0->1 flag transition, -1 per 1->0 transition; flush -> 0.
  - It must always equal popcount(flags).
- An issue to an already-busy register leaves the flag set and busy_cnt unchanged.
- A write to a non-busy register leaves busy_cnt unchanged.
- Mid-operation reset discards all pending state; no write-back is lost silently, since the pipeline is also reset.
- Outputs are undefined only for X on inputs. There are no other don't-care states.

Test Plan:
- Reset, then read all addresses on every port -> every rdata = 0, rbusy = 0, busy_cnt = 0.
- wen[0] with addr 5, data 0xDEADBEEF; same cycle raddr0 = 5 -> rdata0 = 0xDEADBEEF (bypass); next cycle without write -> still 0xDEADBEEF.
- wen[0] addr 7 data 0x11 and wen[1] addr 7 data 0x22 in the same cycle -> same-cycle read = 0x22; stored value = 0x22.
- Write 0xFFFF_FFFF to addr 0 and issue addr 0 -> read addr 0 = 0, rbusy = 0, busy_cnt = 0.
- Scoreboard sequence, addr 3:
  - Issue addr 3 -> next cycle rbusy = 1, busy_cnt = 1.
  - Write addr 3 data 0x42 -> same cycle rbusy = 0 and rdata = 0x42; next cycle busy_cnt = 0.
  - Issue and write addr 3 in the same cycle -> flag remains 1, busy_cnt = 1.
- Issue addrs 1, 2, 4 on consecutive cycles -> busy_cnt = 3; flush together with issue addr 6 -> next cycle all rbusy = 0, busy_cnt = 0; reset asserted mid-sequence -> all state 0 next cycle.

Source files
------------

// File: rtl/regfile_mp_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp_sb
// Description : Multi-port register file with write-back bypass and a
//               per-register pending-write (busy) scoreboard. Entry 0 reads 0.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NR     = 2,
    parameter int NW     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NR*ADDR_W-1:0]   raddr,
    output logic [NR*DATA_W-1:0]   rdata,
    output logic [NR-1:0]          rbusy,
    input  logic [NW-1:0]          wen,
    input  logic [NW*ADDR_W-1:0]   waddr,
    input  logic [NW*DATA_W-1:0]   wdata,
    input  logic                   issue_en,
    input  logic [ADDR_W-1:0]      issue_addr,
    input  logic                   flush,
    output logic [ADDR_W:0]        busy_cnt
);

    localparam int            c_depth = 1 << ADDR_W;
    localparam logic [ADDR_W:0] c_one = 1;

    logic [DATA_W-1:0]  r_mem [c_depth];
    logic [c_depth-1:0] r_busy;
    logic [c_depth-1:0] w_busy_next;
    logic [ADDR_W:0]    r_busy_cnt;
    logic [ADDR_W:0]    w_inc;
    logic [ADDR_W:0]    w_dec;
    logic [ADDR_W:0]    w_cnt_next;

    // Issue is applied after the write clears so a same-cycle producer keeps the flag set.
    always_comb begin
        w_busy_next = r_busy;
        if (flush) begin
            w_busy_next = '0;
        end else begin
            for (int w = 0; w < NW; w++) begin
                if (wen[w]) begin
                    w_busy_next[waddr[w*ADDR_W +: ADDR_W]] = 1'b0;
                end
            end
            if (issue_en) begin
                w_busy_next[issue_addr] = 1'b1;
            end
        end
        w_busy_next[0] = 1'b0;
    end

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int a = 1; a < c_depth; a++) begin
            if (w_busy_next[a] && !r_busy[a]) begin
                w_inc = w_inc + c_one;
            end
            if (!w_busy_next[a] && r_busy[a]) begin
                w_dec = w_dec + c_one;
            end
        end
        w_cnt_next = flush ? '0 : (r_busy_cnt + w_inc - w_dec);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < c_depth; a++) begin
                r_mem[a] <= '0;
            end
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            // Later ports overwrite earlier ones, so the highest index wins.
            for (int w = 0; w < NW; w++) begin
                if (wen[w] && (waddr[w*ADDR_W +: ADDR_W] != '0)) begin
                    r_mem[waddr[w*ADDR_W +: ADDR_W]] <= wdata[w*DATA_W +: DATA_W];
                end
            end
            r_busy     <= w_busy_next;
            r_busy_cnt <= w_cnt_next;
        end
    end

    assign busy_cnt = r_busy_cnt;

    for (genvar gi = 0; gi < NR; gi++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic              w_hit;
        logic [DATA_W-1:0] w_byp;

        assign w_ra = raddr[gi*ADDR_W +: ADDR_W];

        always_comb begin
            w_hit = 1'b0;
            w_byp = '0;
            for (int w = 0; w < NW; w++) begin
                if (wen[w] && (waddr[w*ADDR_W +: ADDR_W] == w_ra)) begin
                    w_hit = 1'b1;
                    w_byp = wdata[w*DATA_W +: DATA_W];
                end
            end
        end

        assign rdata[gi*DATA_W +: DATA_W] = (w_ra == '0) ? '0 : (w_hit ? w_byp : r_mem[w_ra]);
        assign rbusy[gi] = (w_ra != '0) && r_busy[w_ra] && !w_hit;
    end

endmodule
`default_nettype wire
